xor_frame_accumulator: RTL
==========================

XOR_FRAME_ACCUMULATOR -- requirements
Module: xor_frame_accumulator

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter MAX_WORDS, default 16, maximum words per frame (>=1); CNT_W = $clog2(MAX_WORDS+1).
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 IN_VALID  input  1  IN_DATA/IN_LAST valid this cycle.
REQ-006 IN_READY  output  1  block accepts an input word this cycle.
REQ-007 IN_DATA  input  WIDTH  data word.
REQ-008 IN_LAST  input  1  marks final word of frame.
REQ-009 OUT_VALID  output  1  frame result available.
REQ-010 OUT_READY  input  1  consumer accepts result this cycle.
REQ-011 OUT_DATA  output  WIDTH  bitwise XOR of all words in frame.
REQ-012 OUT_PARITY  output  1  reduction XOR of OUT_DATA.
REQ-013 OUT_COUNT  output  CNT_W  number of words in frame.
REQ-014 OUT_OVF  output  1  frame closed by MAX_WORDS limit, not IN_LAST.

Function
REQ-015 Input transfer occurs when IN_VALID=1 and IN_READY=1 on a rising edge; output transfer when OUT_VALID=1 and OUT_READY=1.
REQ-016 FSM states IDLE, ACCUM, DONE; encoding fixed in package.
REQ-017 IDLE: IN_READY=1, OUT_VALID=0, accumulator=0, count=0; on transfer: acc<=IN_DATA, count<=1; go DONE if IN_LAST or MAX_WORDS=1, else ACCUM.
REQ-018 ACCUM: IN_READY=1; on transfer acc<=acc^IN_DATA, count<=count+1; go DONE if IN_LAST or count+1=MAX_WORDS.
REQ-019 ACCUM without transfer: state, acc, count hold (no timeout).
REQ-020 DONE: IN_READY=0, OUT_VALID=1; OUT_DATA, OUT_PARITY, OUT_COUNT, OUT_OVF stable until output transfer; on transfer go IDLE and clear acc/count/OVF.
REQ-021 Latency: OUT_VALID asserts the cycle after the closing word transfer; one-cycle bubble after output transfer before next input accepted (no bypass).
REQ-022 OUT_OVF=1 only when frame closed by count reaching MAX_WORDS with IN_LAST=0; MAX_WORDS-th word with IN_LAST=1 gives OUT_OVF=0.
REQ-023 IN_LAST on a word not transferred is ignored.
REQ-024 OUT_PARITY combinational from registered OUT_DATA; no glitch-relevant paths to inputs.
REQ-025 Outputs outside DONE: OUT_DATA=0, OUT_PARITY=0, OUT_COUNT=0, OUT_OVF=0.

Reset
REQ-026 RST_N low: state=IDLE, acc=0, count=0, OVF=0, OUT_VALID=0 immediately, regardless of CLK.
REQ-027 Reset mid-frame or in DONE discards the frame; first transfer after RST_N rises starts a new frame.
REQ-028 IN_READY=1 during and after reset (IDLE).

Structure
REQ-029 Package xor_pkg holds FSM state encoding and default WIDTH/MAX_WORDS constants.
REQ-030 One sub-module xor_reduce (parameter WIDTH, combinational reduction XOR) produces OUT_PARITY.
REQ-031 Single always block per register group; no latches; no multiple clocks.

Verification (WIDTH=8, MAX_WORDS=4 unless stated)
REQ-032 Frame 0x0F,0xF0,0xFF(last) -> next cycle OUT_VALID=1, OUT_DATA=0x00, OUT_PARITY=0, OUT_COUNT=3, OUT_OVF=0.
REQ-033 Single word 0x07 with IN_LAST -> OUT_DATA=0x07, OUT_PARITY=1, OUT_COUNT=1.
REQ-034 0x01,0x02,0x04,0x08 without IN_LAST -> DONE after 4th, OUT_DATA=0x0F, OUT_COUNT=4, OUT_OVF=1.
REQ-035 OUT_READY low 3 cycles in DONE with IN_VALID=1 -> outputs stable, IN_READY=0, no word consumed; word accepted in IDLE after release.
REQ-036 RST_N pulsed after 2 words of a frame -> OUT_VALID=0, counters 0 asynchronously; next frame 0x55(last) -> OUT_DATA=0x55, OUT_COUNT=1.
REQ-037 WIDTH=1, two-word frames (A,B) over 00,01,10,11 -> OUT_DATA = 0,1,1,0.

Source files
------------

// File: rtl/xor_pkg.sv
// Purpose: shared constants and FSM state encoding for the XOR frame accumulator.
// Contents: default WIDTH / MAX_WORDS values and the state_t enum used by the top level.
// No ports; imported by xor_frame_accumulator.
package xor_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_WORDS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/xor_reduce.sv
// Purpose: combinational reduction XOR of a WIDTH-bit word (parity bit).
// Ports: i_data - word to reduce; o_parity - XOR of all bits of i_data.
// Latency: zero (pure combinational), no flow control.
module xor_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_parity
);

  assign o_parity = ^i_data;

endmodule

// File: rtl/xor_frame_accumulator.sv
// Purpose: XORs all words of an input frame and presents data/parity/count/overflow once per frame.
// Ports: i_clk/i_rst_n (async active-low); input valid/ready/data/last; output valid/ready/data/parity/count/ovf.
// Latency: result valid the cycle after the closing word; input stalled while a result is pending.
module xor_frame_accumulator
  import xor_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_WORDS = DEF_MAX_WORDS,
  localparam int CNT_W    = $clog2(MAX_WORDS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_last,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_parity,
  output logic [CNT_W-1:0] o_out_count,
  output logic             o_out_ovf
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;

  logic             w_word_xfer;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_frame_full;
  logic             w_done;
  logic [WIDTH-1:0] w_out_data;

  assign w_done       = (r_state == ST_DONE);
  assign o_in_ready   = !w_done;
  assign w_word_xfer  = i_in_valid && !w_done;
  // count is 0 in IDLE, so the same increment serves the first word of a frame.
  assign w_count_inc  = r_count + 1'b1;
  assign w_frame_full = (w_count_inc == MAX_CNT);

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      ST_IDLE, ST_ACCUM: begin
        if (w_word_xfer) begin
          w_acc_nxt   = ((r_state == ST_IDLE) ? '0 : r_acc) ^ i_in_data;
          w_count_nxt = w_count_inc;
          if (i_in_last || w_frame_full) begin
            w_state_nxt = ST_DONE;
            // Overflow only when the limit, not IN_LAST, closed the frame.
            w_ovf_nxt   = !i_in_last;
          end else begin
            w_state_nxt = ST_ACCUM;
          end
        end
      end
      ST_DONE: begin
        if (i_out_ready) begin
          w_state_nxt = ST_IDLE;
          w_acc_nxt   = '0;
          w_count_nxt = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_acc_nxt   = '0;
        w_count_nxt = '0;
        w_ovf_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Partial accumulations are hidden: every result field reads zero outside DONE.
  assign o_out_valid = w_done;
  assign w_out_data  = w_done ? r_acc : '0;
  assign o_out_data  = w_out_data;
  assign o_out_count = w_done ? r_count : '0;
  assign o_out_ovf   = w_done && r_ovf;

  xor_reduce #(
    .WIDTH (WIDTH)
  ) u_parity (
    .i_data   (w_out_data),
    .o_parity (o_out_parity)
  );

endmodule
